// File: rtl/check_restore_if.sv
// check_restore_if: port bundle of the serial min-sum check-node output stage.
//
// Handshake rule for both streams: a beat transfers on the rising clk edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge; ready may be driven from state only, never
// from the same stream's valid.
//
// master: the upstream/downstream side (subtract stage + write-back).
// slave : the check_restore block itself.
// dbg_state exposes the FSM state of the block for checkers.
interface check_restore_if #(
    parameter int W    = 8,
    parameter int IDXW = 3
);
    logic            in_valid;
    logic            in_ready;
    logic            sign_in;
    logic [W-1:0]    mag_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    r_out;
    logic [W-1:0]    q_out;
    logic [IDXW-1:0] edge_idx;
    logic [1:0]      dbg_state;

    modport master (
        output in_valid, sign_in, mag_in, out_ready,
        input  in_ready, out_valid, r_out, q_out, edge_idx, dbg_state
    );

    modport slave (
        input  in_valid, sign_in, mag_in, out_ready,
        output in_ready, out_valid, r_out, q_out, edge_idx, dbg_state
    );
endinterface

// File: rtl/check_restore.sv
// check_restore: serial check-node output stage of a min-sum LDPC decoder.
//
// Collects DEG sign-magnitude q_temp beats of one check row, tracking min1,
// min2, the min1 edge index and the sign product. It then emits, one edge per
// handshake, the new check-to-variable message r (two's complement) and the
// restored posterior q = q_temp + r, saturated to a symmetric range.
//
// Build option: define OFFSET_MS_EN for offset min-sum (|r| reduced by
// OFFSET, floored at zero). Without it the block is plain min-sum and the
// OFFSET parameter has no effect.
module check_restore #(
    parameter int W      = 8,
    parameter int DEG    = 6,
    parameter int IDXW   = 3,
    parameter int OFFSET = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    check_restore_if.slave bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST    = IDXW'(DEG - 1);
    // Largest representable positive message, 2^(W-1)-1.
    localparam logic [W-1:0]    MAG_MAX = {1'b0, {(W-1){1'b1}}};
    // Symmetric saturation bounds at the W+2 bit sum width.
    localparam logic [W+1:0]    SUM_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic [W+1:0]    SUM_MIN = (W+2)'(0) - SUM_MAX;

`ifdef OFFSET_MS_EN
    localparam logic [W-1:0]    OFF_W   = W'(OFFSET);
`else
    localparam int              unused_offset = OFFSET;
`endif

    state_t          state;
    state_t          state_nx;

    logic [IDXW-1:0] cnt;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    min1;
    logic [W-1:0]    min2;
    logic            sprod;

    logic            buf_sign [DEG];
    logic [W-1:0]    buf_mag  [DEG];

    logic            out_valid_q;
    logic [W-1:0]    r_q;
    logic [W-1:0]    q_q;
    logic [IDXW-1:0] edge_q;

    logic            cnt_last;
    logic            in_fire;
    logic            out_fire;

    logic [IDXW-1:0] sel_idx;
    logic            sel_sign;
    logic [W-1:0]    sel_mag;
    logic [W-1:0]    m_sel;
    logic [W-1:0]    m_clamp;
    logic [W-1:0]    m_eff;
    logic [W-1:0]    r_calc;
    logic [W:0]      q_tmp;
    logic [W+1:0]    q_sum;
    logic [W-1:0]    q_calc;

    assign cnt_last = (cnt == LAST);
    assign in_fire  = (state == COLLECT) && bus.in_valid;
    assign out_fire = (state == EMIT) && out_valid_q && bus.out_ready;

    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = out_valid_q;
    assign bus.r_out     = r_q;
    assign bus.q_out     = q_q;
    assign bus.edge_idx  = edge_q;
    assign bus.dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: one row in, LOAD the first edge, stream DEG edges out.
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (in_fire && cnt_last)  state_nx = LOAD;
            LOAD:                              state_nx = EMIT;
            EMIT:    if (out_fire && cnt_last) state_nx = COLLECT;
            default:                           state_nx = COLLECT;
        endcase
    end

    // Row buffer: contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_sign[cnt] <= bus.sign_in;
            buf_mag[cnt]  <= bus.mag_in;
        end
    end

    // Edge selection and per-edge r / q arithmetic. In EMIT the next edge is
    // prepared so an accepted output is replaced in the same cycle.
    always_comb begin
        sel_idx  = ((state == EMIT) && !cnt_last) ? cnt + IDXW'(1) : cnt;
        sel_sign = buf_sign[sel_idx];
        sel_mag  = buf_mag[sel_idx];

        m_sel   = (sel_idx == idx) ? min2 : min1;
        m_clamp = (m_sel > MAG_MAX) ? MAG_MAX : m_sel;
`ifdef OFFSET_MS_EN
        m_eff   = (m_clamp > OFF_W) ? m_clamp - OFF_W : '0;
`else
        m_eff   = m_clamp;
`endif
        // Negating zero yields zero, so m=0 gives r=0 for either sign.
        r_calc = (sprod ^ sel_sign) ? W'(0) - m_eff : m_eff;

        q_tmp  = sel_sign ? (W+1)'(0) - {1'b0, sel_mag} : {1'b0, sel_mag};
        q_sum  = {q_tmp[W], q_tmp} + {{2{r_calc[W-1]}}, r_calc};

        if ($signed(q_sum) > $signed(SUM_MAX)) begin
            q_calc = MAG_MAX;
        end else if ($signed(q_sum) < $signed(SUM_MIN)) begin
            q_calc = W'(0) - MAG_MAX;
        end else begin
            q_calc = q_sum[W-1:0];
        end
    end

    // Row statistics, edge counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            min1        <= '1;
            min2        <= '1;
            sprod       <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            q_q         <= '0;
            edge_q      <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        sprod <= sprod ^ bus.sign_in;
                        // Strict compares: a tie with min1 lands in min2.
                        if (bus.mag_in < min1) begin
                            min2 <= min1;
                            min1 <= bus.mag_in;
                            idx  <= cnt;
                        end else if (bus.mag_in < min2) begin
                            min2 <= bus.mag_in;
                        end
                        cnt <= cnt_last ? '0 : cnt + IDXW'(1);
                    end
                end
                LOAD: begin
                    out_valid_q <= 1'b1;
                    r_q         <= r_calc;
                    q_q         <= q_calc;
                    edge_q      <= sel_idx;
                end
                EMIT: begin
                    if (out_fire) begin
                        if (cnt_last) begin
                            out_valid_q <= 1'b0;
                            min1        <= '1;
                            min2        <= '1;
                            sprod       <= 1'b0;
                            cnt         <= '0;
                        end else begin
                            cnt    <= cnt + IDXW'(1);
                            r_q    <= r_calc;
                            q_q    <= q_calc;
                            edge_q <= sel_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_check_restore.sv
// tb_check_restore: bench for check_restore (W=8, DEG=6). Table rows with
// hand-derived results, multi-cycle corner sequences, and random rows scored
// against a min-over-other-edges reference model.
module tb_check_restore;

    localparam int W      = 8;
    localparam int DEG    = 6;
    localparam int IDXW   = 3;
    localparam int OFFSET = 1;
`ifdef OFFSET_MS_EN
    localparam int OFS    = OFFSET;
`else
    localparam int OFS    = 0;
`endif
    localparam int EW     = IDXW + 2 * W;
    localparam int NVEC   = 4;

    typedef struct {
        int mag [DEG];
        bit sg  [DEG];
        int er  [DEG];
        int eq  [DEG];
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int in_edges[$];
    int out_edges[$];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_w;
    logic [EW-1:0] exp_w;
    vec_t vt [NVEC];

    check_restore_if #(.W(W), .IDXW(IDXW)) bus ();

    check_restore #(
        .W(W), .DEG(DEG), .IDXW(IDXW), .OFFSET(OFFSET)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: handshakes are seen at the negedge before the edge that
    // completes them; cyc+1 is that edge's number.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) in_edges.push_back(cyc + 1);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            out_edges.push_back(cyc + 1);
            got_w = {bus.edge_idx, bus.r_out, bus.q_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: edge %0d r %0d q %0d with nothing expected",
                         bus.edge_idx, $signed(bus.r_out), $signed(bus.q_out));
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    errors++;
                    $display("FAIL out_word: got edge %0d r %0d q %0d expected edge %0d r %0d q %0d",
                             got_w[EW-1 -: IDXW], $signed(got_w[2*W-1 -: W]), $signed(got_w[W-1:0]),
                             exp_w[EW-1 -: IDXW], $signed(exp_w[2*W-1 -: W]), $signed(exp_w[W-1:0]));
                end
            end
        end
    end

    // Reference model: r_j uses the minimum and sign product over all other
    // edges of the row; q_j is the signed sum saturated symmetrically.
    task automatic push_model(input int mags [DEG], input bit sg [DEG]);
        for (int j = 0; j < DEG; j++) begin
            int m, r, q, qt;
            bit sp;
            m = 1 << 30;
            sp = 0;
            for (int k = 0; k < DEG; k++) begin
                if (k != j) begin
                    if (mags[k] < m) m = mags[k];
                    sp ^= sg[k];
                end
            end
            if (m > 127) m = 127;
            m = (m > OFS) ? m - OFS : 0;
            r = sp ? -m : m;
            qt = sg[j] ? -mags[j] : mags[j];
            q = qt + r;
            if (q > 127) q = 127;
            if (q < -127) q = -127;
            exp_q.push_back({IDXW'(j), W'(r), W'(q)});
        end
    endtask

    task automatic push_table(input int n);
        for (int j = 0; j < DEG; j++)
            exp_q.push_back({IDXW'(j), W'(vt[n].er[j]), W'(vt[n].eq[j])});
    endtask

    // Driver: present one beat and hold it until accepted.
    task automatic send_beat(input bit s, input int m);
        int t;
        bus.in_valid = 1'b1;
        bus.sign_in  = s;
        bus.mag_in   = W'(m);
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready 0 for %0d cycles, expected 1", t);
        end
        check("out_valid_in_collect", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_row(input int mags [DEG], input bit sg [DEG]);
        for (int k = 0; k < DEG; k++) send_beat(sg[k], mags[k]);
    endtask

    task automatic wait_drain(input bit rand_ready);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            t++;
        end
        bus.out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        check("in_ready_after_row", int'(bus.in_ready), 1);
    endtask

    initial begin
        int t;
        int mags [DEG];
        bit sg [DEG];

        vt[0].mag = '{5, 3, 9, 3, 7, 12};
        vt[0].sg  = '{0, 1, 0, 0, 1, 0};
        vt[0].er  = '{3-OFS, -(3-OFS), 3-OFS, 3-OFS, -(3-OFS), 3-OFS};
        vt[0].eq  = '{8-OFS, -6+OFS, 12-OFS, 6-OFS, -10+OFS, 15-OFS};

        vt[1].mag = '{200, 150, 180, 190, 170, 160};
        vt[1].sg  = '{0, 0, 0, 0, 0, 0};
        vt[1].er  = '{127-OFS, 127-OFS, 127-OFS, 127-OFS, 127-OFS, 127-OFS};
        vt[1].eq  = '{127, 127, 127, 127, 127, 127};

        vt[2].mag = '{200, 150, 180, 190, 170, 160};
        vt[2].sg  = '{1, 1, 1, 1, 1, 1};
        vt[2].er  = '{-(127-OFS), -(127-OFS), -(127-OFS), -(127-OFS), -(127-OFS), -(127-OFS)};
        vt[2].eq  = '{-127, -127, -127, -127, -127, -127};

        vt[3].mag = '{8, 0, 6, 5, 9, 7};
        vt[3].sg  = '{1, 0, 0, 1, 0, 0};
        vt[3].er  = '{0, 5-OFS, 0, 0, 0, 0};
        vt[3].eq  = '{-8, 5-OFS, 6, -5, 9, 7};

        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.mag_in    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_r_out", int'(bus.r_out), 0);
        check("rst_q_out", int'(bus.q_out), 0);
        check("rst_edge_idx", int'(bus.edge_idx), 0);
        check("rst_state", int'(bus.dbg_state), 0);
        rst_n = 1'b1;

        // Table rows.
        for (int n = 0; n < NVEC; n++) begin
            push_table(n);
            send_row(vt[n].mag, vt[n].sg);
            wait_drain(1'b0);
        end

        // Backpressure: hold edge 2 for three cycles.
        push_table(0);
        send_row(vt[0].mag, vt[0].sg);
        t = 0;
        while (!(bus.out_valid && bus.edge_idx == 3'd2) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_reach_edge2", int'(bus.out_valid && bus.edge_idx == 3'd2), 1);
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_edge_held", int'(bus.edge_idx), 2);
            check("bp_r_held", int'($signed(bus.r_out)), vt[0].er[2]);
            check("bp_q_held", int'($signed(bus.q_out)), vt[0].eq[2]);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain(1'b0);

        // Reset mid-row: three beats then a one-cycle reset pulse.
        for (int k = 0; k < 3; k++) send_beat(1'($urandom_range(0, 1)), $urandom_range(0, 255));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        push_table(0);
        send_row(vt[0].mag, vt[0].sg);
        @(negedge clk);
        check("midrst_load_out_valid", int'(bus.out_valid), 0);
        wait_drain(1'b0);

        // Latency: two rows back to back, out_ready held high; the second
        // row's first beat waits with in_valid high through LOAD/EMIT.
        in_edges.delete();
        out_edges.delete();
        push_table(0);
        push_table(3);
        send_row(vt[0].mag, vt[0].sg);
        send_row(vt[3].mag, vt[3].sg);
        wait_drain(1'b0);
        check("lat_in_count", in_edges.size(), 2 * DEG);
        check("lat_out_count", out_edges.size(), 2 * DEG);
        if (in_edges.size() == 2 * DEG && out_edges.size() == 2 * DEG) begin
            check("lat_first_out", out_edges[0], in_edges[DEG-1] + 2);
            for (int k = 1; k < DEG; k++)
                check("lat_contiguous", out_edges[k], out_edges[0] + k);
            check("lat_next_in", in_edges[DEG], out_edges[DEG-1] + 1);
            check("lat_second_out", out_edges[DEG], in_edges[2*DEG-1] + 2);
        end

        // Random rows against the reference model, random backpressure.
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < DEG; k++) begin
                case (mode)
                    0:       mags[k] = $urandom_range(0, 255);
                    1:       mags[k] = $urandom_range(0, 4);
                    default: mags[k] = $urandom_range(120, 255);
                endcase
                sg[k] = 1'($urandom_range(0, 1));
            end
            push_model(mags, sg);
            send_row(mags, sg);
            wait_drain(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
